// File: rtl/gpio_cfg_serializer.sv
// Serialises parallel config-register writes onto the GPIO config bus (sdata + per-register strobe) and emits single-line pulses.
// Latency: gpio_out registered, first bit one cycle after acceptance; shift busy (2N+1)*CLK_DIV, pulse W*CLK_DIV, then one done/err cycle.
// Backpressure: cmd_ready only in IDLE; one command in flight, no queueing.
module gpio_cfg_serializer #(
    parameter int GPIO_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_op,
    input  logic [7:0]                      cmd_line,
    input  logic [DATA_WIDTH-1:0]           cmd_data,
    input  logic [$clog2(DATA_WIDTH+1)-1:0] cmd_nbits,
    output logic [GPIO_WIDTH-1:0]           gpio_out,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);
    localparam int NBW = $clog2(DATA_WIDTH+1);
    localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CW  = $clog2(CLK_DIV*DATA_WIDTH+1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV-1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        HOLD,
        PULSE,
        DONE
    } state_t;

    typedef struct packed {
        logic [GPIO_WIDTH-1:0] line_mask;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    state_t                state_q, state_nxt;
    logic [CW-1:0]         cnt_q, cnt_nxt;
    logic [BW-1:0]         bit_q, bit_nxt;
    cmd_t                  cmd_q, cmd_nxt;
    logic                  err_q, err_nxt;
    logic [GPIO_WIDTH-1:0] gpio_q, gpio_nxt;
    logic                  cmd_bad;

    assign cmd_bad = (cmd_line == 8'd0)
                  || (32'(cmd_line) >= GPIO_WIDTH)
                  || (cmd_nbits == '0)
                  || (32'(cmd_nbits) > DATA_WIDTH);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            cmd_q   <= '0;
            err_q   <= 1'b0;
            gpio_q  <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            bit_q   <= bit_nxt;
            cmd_q   <= cmd_nxt;
            err_q   <= err_nxt;
            gpio_q  <= gpio_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        bit_nxt   = bit_q;
        cmd_nxt   = cmd_q;
        err_nxt   = err_q;
        gpio_nxt  = '0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_nxt.data      = cmd_data;
                    cmd_nxt.line_mask = GPIO_WIDTH'(1) << cmd_line;
                    bit_nxt           = BW'(cmd_nbits - NBW'(1));
                    if (cmd_bad) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else if (cmd_op) begin
                        err_nxt   = 1'b0;
                        cnt_nxt   = CW'(cmd_nbits) * CW'(CLK_DIV) - CW'(1);
                        state_nxt = PULSE;
                    end else begin
                        err_nxt   = 1'b0;
                        cnt_nxt   = HALF;
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_nxt   = HALF;
                    state_nxt = HIGH;
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    cnt_nxt = HALF;
                    if (bit_q == '0) begin
                        state_nxt = HOLD;
                    end else begin
                        bit_nxt   = bit_q - BW'(1);
                        state_nxt = SETUP;
                    end
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
            HOLD, PULSE: begin
                if (cnt_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Output image follows the state being entered, so gpio_out lines up with it after the edge.
        // bit_nxt only moves on HIGH->SETUP, hence sdata can never change under a high strobe.
        unique case (state_nxt)
            SETUP, HOLD: begin
                gpio_nxt[0] = cmd_nxt.data[bit_nxt];
            end
            HIGH: begin
                gpio_nxt    = cmd_nxt.line_mask;
                gpio_nxt[0] = cmd_nxt.data[bit_nxt];
            end
            PULSE: begin
                gpio_nxt = cmd_nxt.line_mask;
            end
            default: begin
                gpio_nxt = '0;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == SETUP) || (state_q == HIGH)
                    || (state_q == HOLD)  || (state_q == PULSE);
    assign done      = (state_q == DONE) && !err_q;
    assign err       = (state_q == DONE) && err_q;
    assign gpio_out  = gpio_q;

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Bench for gpio_cfg_serializer: command table plus reset and back-to-back sequences.
// Latency: expectations queued at drive time, popped by a bus monitor when done/err fires.
// Backpressure: commands are issued only once cmd_ready is seen high.
module tb_gpio_cfg_serializer;
    localparam int GW = 16;
    localparam int DW = 32;
    localparam int CD = 4;

    logic          clk;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [7:0]    cmd_line;
    logic [DW-1:0] cmd_data;
    logic [5:0]    cmd_nbits;
    logic [GW-1:0] gpio_out;
    logic          busy;
    logic          done;
    logic          err;

    gpio_cfg_serializer #(
        .GPIO_WIDTH(GW),
        .DATA_WIDTH(DW),
        .CLK_DIV   (CD)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_line (cmd_line),
        .cmd_data (cmd_data),
        .cmd_nbits(cmd_nbits),
        .gpio_out (gpio_out),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        logic        op;
        logic [7:0]  line;
        logic [31:0] data;
        logic [5:0]  nbits;
        logic        e_err;
        int          e_busy;
        int          e_rises;
        int          e_hi;
        logic [63:0] e_bits;
    } vec_t;

    vec_t        tbl[12];
    vec_t        exp_q[$];
    int          acc_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    int          m_busy, m_rises, m_hi, m_stray;
    logic [63:0] m_bits;
    logic [GW-1:0] m_prev, m_mask;
    logic        m_ln, m_lp;
    vec_t        m_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rstn && cmd_valid && cmd_ready) acc_q.push_back(cyc);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic mon_clear();
        m_busy  = 0;
        m_rises = 0;
        m_hi    = 0;
        m_stray = 0;
        m_bits  = '0;
    endtask

    // Bus monitor: measures each transfer independently of the DUT's internal state.
    always @(negedge clk) begin
        if (!rstn) begin
            mon_clear();
            m_prev = '0;
        end else begin
            if (exp_q.size() > 0 && !exp_q[0].e_err) m_mask = 16'd1 << exp_q[0].line;
            else m_mask = '0;
            m_ln = |(gpio_out & m_mask);
            m_lp = |(m_prev & m_mask);
            if (busy) m_busy++;
            if (m_ln) m_hi++;
            if (m_ln && !m_lp) begin
                m_rises++;
                m_bits = {m_bits[62:0], gpio_out[0]};
            end
            if ((gpio_out & ~(m_mask | 16'd1)) != '0) m_stray++;
            if (!busy && gpio_out != '0) m_stray++;
            if (m_ln && m_lp && gpio_out[0] != m_prev[0]) m_stray++;
            if (exp_q.size() > 0 && exp_q[0].op && gpio_out[0]) m_stray++;
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("err_flag",   64'(err),  64'(m_e.e_err));
                    check("done_flag",  64'(done), 64'(!m_e.e_err));
                    check("busy_len",   64'(m_busy),  64'(m_e.e_busy));
                    check("rises",      64'(m_rises), 64'(m_e.e_rises));
                    check("line_high",  64'(m_hi),    64'(m_e.e_hi));
                    check("bits",       m_bits,       m_e.e_bits);
                    check("stray_bits", 64'(m_stray), 0);
                end
                mon_clear();
            end
            m_prev = gpio_out;
        end
    end

    task automatic send(input vec_t v);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            check("send_ready_timeout", 0, 1);
        end else begin
            cmd_op    = v.op;
            cmd_line  = v.line;
            cmd_data  = v.data;
            cmd_nbits = v.nbits;
            cmd_valid = 1'b1;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cmd_op    = 1'($urandom);
            cmd_line  = 8'($urandom);
            cmd_data  = $urandom;
            cmd_nbits = 6'($urandom);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            check("completion_timeout", 64'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t a, b;
        int   k;

        //         op    line   data           nbits  err   busy rises hi   bits
        tbl[0]  = '{1'b0, 8'd2,  32'h0000A5C3, 6'd16, 1'b0, 132, 16,  64,  64'hA5C3};
        tbl[1]  = '{1'b1, 8'd6,  32'hFFFFFFFF, 6'd3,  1'b0, 12,  1,   12,  64'h0};
        tbl[2]  = '{1'b0, 8'd0,  32'h12345678, 6'd4,  1'b1, 0,   0,   0,   64'h0};
        tbl[3]  = '{1'b0, 8'd16, 32'h12345678, 6'd4,  1'b1, 0,   0,   0,   64'h0};
        tbl[4]  = '{1'b0, 8'd3,  32'h12345678, 6'd0,  1'b1, 0,   0,   0,   64'h0};
        tbl[5]  = '{1'b0, 8'd3,  32'h12345678, 6'd33, 1'b1, 0,   0,   0,   64'h0};
        tbl[6]  = '{1'b0, 8'd5,  32'h80000001, 6'd32, 1'b0, 260, 32,  128, 64'h80000001};
        tbl[7]  = '{1'b0, 8'd15, 32'hFFFFFFFF, 6'd1,  1'b0, 12,  1,   4,   64'h1};
        tbl[8]  = '{1'b1, 8'd1,  32'h0,        6'd1,  1'b0, 4,   1,   4,   64'h0};
        tbl[9]  = '{1'b1, 8'd15, 32'hFFFFFFFF, 6'd32, 1'b0, 128, 1,   128, 64'h0};
        tbl[10] = '{1'b1, 8'd0,  32'h0,        6'd2,  1'b1, 0,   0,   0,   64'h0};
        tbl[11] = '{1'b0, 8'd9,  32'hFFFFFF15, 6'd5,  1'b0, 44,  5,   20,  64'h15};

        rstn      = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_line  = '0;
        cmd_data  = '0;
        cmd_nbits = '0;
        #2 rstn = 1'b0;
        #1;
        check("rst_gpio",  64'(gpio_out), 0);
        check("rst_ready", 64'(cmd_ready), 1);
        check("rst_busy",  64'(busy), 0);
        check("rst_done",  64'(done), 0);
        check("rst_err",   64'(err), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(cmd_ready), 1);

        for (int i = 0; i < 12; i++) begin
            send(tbl[i]);
            wait_done();
        end

        // Reset while the 5th bit of a 32-bit shift has its strobe high.
        a = '{1'b0, 8'd4, 32'hDEADBEEF, 6'd32, 1'b0, 260, 32, 128, 64'hDEADBEEF};
        send(a);
        repeat (36) @(posedge clk);
        #2;
        check("pre_rst_strobe", 64'(gpio_out[4]), 1);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_gpio",  64'(gpio_out), 0);
        check("midrst_ready", 64'(cmd_ready), 1);
        check("midrst_busy",  64'(busy), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("after_rst_ready", 64'(cmd_ready), 1);
        check("after_rst_gpio",  64'(gpio_out), 0);
        b = '{1'b0, 8'd10, 32'h0000005A, 6'd8, 1'b0, 68, 8, 32, 64'h5A};
        send(b);
        wait_done();

        // cmd_valid held high with fields churning while busy.
        a = '{1'b0, 8'd3, 32'h0000000A, 6'd4, 1'b0, 36, 4, 16, 64'hA};
        b = '{1'b1, 8'd7, 32'h00000000, 6'd2, 1'b0, 8,  1, 8,  64'h0};
        @(negedge clk);
        acc_q.delete();
        cmd_op    = a.op;
        cmd_line  = a.line;
        cmd_data  = a.data;
        cmd_nbits = a.nbits;
        cmd_valid = 1'b1;
        exp_q.push_back(a);
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!cmd_ready) begin
                cmd_op    = 1'($urandom);
                cmd_line  = 8'($urandom);
                cmd_data  = $urandom;
                cmd_nbits = 6'($urandom);
            end
        end while (!cmd_ready && k < 200);
        cmd_op    = b.op;
        cmd_line  = b.line;
        cmd_data  = b.data;
        cmd_nbits = b.nbits;
        exp_q.push_back(b);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done();
        check("b2b_accepts", 64'(acc_q.size()), 2);
        if (acc_q.size() >= 2) check("b2b_spacing", 64'(acc_q[1] - acc_q[0]), 38);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
